// File: rtl/dda_stepper.sv
// dda_stepper: Amanatides-Woo voxel walker over a 32x32x32 grid.
// One occupancy lookup per visited voxel; reports a hit, a grid exit or an
// exhausted step budget, and pulses job_done once per accepted job.
module dda_stepper #(
  parameter int W = 24
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         job_loaded,
  input  logic [4:0]   ix0_reg,
  input  logic [4:0]   iy0_reg,
  input  logic [4:0]   iz0_reg,
  input  logic         sx_reg,
  input  logic         sy_reg,
  input  logic         sz_reg,
  input  logic [W-1:0] next_x_reg,
  input  logic [W-1:0] next_y_reg,
  input  logic [W-1:0] next_z_reg,
  input  logic [W-1:0] inc_x_reg,
  input  logic [W-1:0] inc_y_reg,
  input  logic [W-1:0] inc_z_reg,
  input  logic [9:0]   max_steps_reg,
  output logic         occ_req,
  output logic [4:0]   occ_ix,
  output logic [4:0]   occ_iy,
  output logic [4:0]   occ_iz,
  input  logic         occ_hit,
  output logic         job_done,
  output logic         res_hit,
  output logic         res_exit,
  output logic [4:0]   res_ix,
  output logic [4:0]   res_iy,
  output logic [4:0]   res_iz,
  output logic [1:0]   res_axis,
  output logic [9:0]   res_steps
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOOKUP,
    CHECK,
    DONE
  } state_t;

  state_t       state_q;
  logic [4:0]   cx_q, cy_q, cz_q;
  logic [W-1:0] tx_q, ty_q, tz_q;
  logic [9:0]   steps_q;
  logic [1:0]   lastAxis_q;

  logic         occReq_q;
  logic [4:0]   occIx_q, occIy_q, occIz_q;
  logic         jobDone_q;
  logic         resHit_q, resExit_q;
  logic [4:0]   resIx_q, resIy_q, resIz_q;
  logic [1:0]   resAxis_q;
  logic [9:0]   resSteps_q;

  logic [1:0]   axis_d;
  logic         leave_d;
  logic         budgetOut_d;
  logic         finish_d;
  logic         resExit_d;
  logic [4:0]   cx_d, cy_d, cz_d;
  logic [W-1:0] tx_d, ty_d, tz_d;

  // Unsigned add that clamps at the all-ones timer value instead of wrapping.
  function automatic logic [W-1:0] satAdd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[W] ? {W{1'b1}} : sum[W-1:0];
  endfunction

  // Pick the stepping axis (smallest timer, ties x>y>z) and the would-be next voxel/timers.
  always_comb begin
    axis_d = 2'd3;
    if ((tx_q <= ty_q) && (tx_q <= tz_q)) begin
      axis_d = 2'd1;
    end else if (ty_q <= tz_q) begin
      axis_d = 2'd2;
    end

    cx_d = cx_q;
    cy_d = cy_q;
    cz_d = cz_q;
    tx_d = tx_q;
    ty_d = ty_q;
    tz_d = tz_q;
    leave_d = 1'b0;
    case (axis_d)
      2'd1: begin
        leave_d = sx_reg ? (cx_q == 5'd31) : (cx_q == 5'd0);
        cx_d    = sx_reg ? (cx_q + 5'd1) : (cx_q - 5'd1);
        tx_d    = satAdd(tx_q, inc_x_reg);
      end
      2'd2: begin
        leave_d = sy_reg ? (cy_q == 5'd31) : (cy_q == 5'd0);
        cy_d    = sy_reg ? (cy_q + 5'd1) : (cy_q - 5'd1);
        ty_d    = satAdd(ty_q, inc_y_reg);
      end
      default: begin
        leave_d = sz_reg ? (cz_q == 5'd31) : (cz_q == 5'd0);
        cz_d    = sz_reg ? (cz_q + 5'd1) : (cz_q - 5'd1);
        tz_d    = satAdd(tz_q, inc_z_reg);
      end
    endcase

    budgetOut_d = (steps_q == max_steps_reg);
    finish_d    = occ_hit || budgetOut_d || leave_d;
    resExit_d   = !occ_hit && !budgetOut_d && leave_d;
  end

  // Traversal FSM with registered lookup strobe, completion pulse and results.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      cz_q       <= '0;
      tx_q       <= '0;
      ty_q       <= '0;
      tz_q       <= '0;
      steps_q    <= '0;
      lastAxis_q <= '0;
      occReq_q   <= 1'b0;
      occIx_q    <= '0;
      occIy_q    <= '0;
      occIz_q    <= '0;
      jobDone_q  <= 1'b0;
      resHit_q   <= 1'b0;
      resExit_q  <= 1'b0;
      resIx_q    <= '0;
      resIy_q    <= '0;
      resIz_q    <= '0;
      resAxis_q  <= '0;
      resSteps_q <= '0;
    end else begin
      occReq_q  <= 1'b0;
      jobDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (job_loaded) begin
            state_q <= INIT;
          end
        end
        INIT: begin
          cx_q       <= ix0_reg;
          cy_q       <= iy0_reg;
          cz_q       <= iz0_reg;
          tx_q       <= next_x_reg;
          ty_q       <= next_y_reg;
          tz_q       <= next_z_reg;
          steps_q    <= '0;
          lastAxis_q <= 2'd0;
          occReq_q   <= 1'b1;
          occIx_q    <= ix0_reg;
          occIy_q    <= iy0_reg;
          occIz_q    <= iz0_reg;
          state_q    <= LOOKUP;
        end
        LOOKUP: begin
          state_q <= CHECK;
        end
        CHECK: begin
          if (finish_d) begin
            resHit_q   <= occ_hit;
            resExit_q  <= resExit_d;
            resIx_q    <= cx_q;
            resIy_q    <= cy_q;
            resIz_q    <= cz_q;
            resAxis_q  <= lastAxis_q;
            resSteps_q <= steps_q;
            jobDone_q  <= 1'b1;
            state_q    <= DONE;
          end else begin
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            cz_q       <= cz_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            tz_q       <= tz_d;
            steps_q    <= steps_q + 10'd1;
            lastAxis_q <= axis_d;
            occReq_q   <= 1'b1;
            occIx_q    <= cx_d;
            occIy_q    <= cy_d;
            occIz_q    <= cz_d;
            state_q    <= LOOKUP;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign occ_req   = occReq_q;
  assign occ_ix    = occIx_q;
  assign occ_iy    = occIy_q;
  assign occ_iz    = occIz_q;
  assign job_done  = jobDone_q;
  assign res_hit   = resHit_q;
  assign res_exit  = resExit_q;
  assign res_ix    = resIx_q;
  assign res_iy    = resIy_q;
  assign res_iz    = resIz_q;
  assign res_axis  = resAxis_q;
  assign res_steps = resSteps_q;

endmodule

// File: tb/tb_dda_stepper.sv
// tb_dda_stepper: directed and randomized traversal jobs checked cycle by
// cycle against a plain-arithmetic ray-walk model with an occupancy map.
module tb_dda_stepper;

  localparam int W = 24;
  localparam longint MAXT = (longint'(1) << W) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         jobLoaded = 1'b0;
  logic [4:0]   ix0 = '0, iy0 = '0, iz0 = '0;
  logic         sx = 1'b0, sy = 1'b0, sz = 1'b0;
  logic [W-1:0] nextX = '0, nextY = '0, nextZ = '0;
  logic [W-1:0] incX = '0, incY = '0, incZ = '0;
  logic [9:0]   maxSteps = '0;
  logic         occHit = 1'b0;

  logic         occ_req;
  logic [4:0]   occ_ix, occ_iy, occ_iz;
  logic         job_done, res_hit, res_exit;
  logic [4:0]   res_ix, res_iy, res_iz;
  logic [1:0]   res_axis;
  logic [9:0]   res_steps;

  logic [28:0]  resObs;
  assign resObs = {res_hit, res_exit, res_ix, res_iy, res_iz, res_axis, res_steps};

  bit           occMap [32768];
  logic [14:0]  expAddr [$];
  int           expK;
  logic [28:0]  expRes;
  logic [14:0]  lastAddr = '0;
  logic [28:0]  lastRes = '0;
  int           total = 0;
  int           bad = 0;
  int           jobNum = 0;

  dda_stepper #(.W(W)) dut (
    .clock(clock), .reset(reset), .job_loaded(jobLoaded),
    .ix0_reg(ix0), .iy0_reg(iy0), .iz0_reg(iz0),
    .sx_reg(sx), .sy_reg(sy), .sz_reg(sz),
    .next_x_reg(nextX), .next_y_reg(nextY), .next_z_reg(nextZ),
    .inc_x_reg(incX), .inc_y_reg(incY), .inc_z_reg(incZ),
    .max_steps_reg(maxSteps),
    .occ_req(occ_req), .occ_ix(occ_ix), .occ_iy(occ_iy), .occ_iz(occ_iz),
    .occ_hit(occHit), .job_done(job_done),
    .res_hit(res_hit), .res_exit(res_exit),
    .res_ix(res_ix), .res_iy(res_iy), .res_iz(res_iz),
    .res_axis(res_axis), .res_steps(res_steps)
  );

  always #5 clock = ~clock;

  // Occupancy memory: answers one cycle after a request, garbage otherwise.
  always @(posedge clock) begin
    if (occ_req) occHit <= occMap[{occ_ix, occ_iy, occ_iz}];
    else         occHit <= 1'($urandom);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fillMap(input int density);
    for (int i = 0; i < 32768; i++)
      occMap[i] = (density != 0) && ($urandom_range(0, density - 1) == 0);
  endtask

  // Ray walk from the rules: look up, stop on hit/budget/exit, else step the min timer.
  task automatic modelJob();
    int p[3];
    longint t[3];
    longint inc[3];
    bit s[3];
    int steps, axis, k, np;
    bit hit, ex;
    p[0] = int'(ix0); p[1] = int'(iy0); p[2] = int'(iz0);
    t[0] = longint'(nextX); t[1] = longint'(nextY); t[2] = longint'(nextZ);
    inc[0] = longint'(incX); inc[1] = longint'(incY); inc[2] = longint'(incZ);
    s[0] = sx; s[1] = sy; s[2] = sz;
    expAddr.delete();
    steps = 0; axis = 0; hit = 0; ex = 0;
    for (int guard = 0; guard < 2000; guard++) begin
      expAddr.push_back({5'(p[0]), 5'(p[1]), 5'(p[2])});
      if (occMap[p[0] * 1024 + p[1] * 32 + p[2]]) begin hit = 1; break; end
      if (steps == int'(maxSteps)) break;
      k = 0;
      if (t[1] < t[k]) k = 1;
      if (t[2] < t[k]) k = 2;
      np = p[k] + (s[k] ? 1 : -1);
      if (np < 0 || np > 31) begin ex = 1; break; end
      p[k] = np;
      t[k] = t[k] + inc[k];
      if (t[k] > MAXT) t[k] = MAXT;
      steps++;
      axis = k + 1;
    end
    expK = steps;
    expRes = {hit, ex, 5'(p[0]), 5'(p[1]), 5'(p[2]), 2'(axis), 10'(steps)};
  endtask

  // Launch the job held in the parameter variables and check every cycle to completion.
  task automatic applyStimulus();
    int doneCyc;
    logic expReq;
    modelJob();
    jobNum++;
    doneCyc = 4 + 2 * expK;
    @(negedge clock);
    @(negedge clock);
    jobLoaded = 1'b1;
    for (int c = 1; c <= doneCyc + 1; c++) begin
      @(negedge clock);
      jobLoaded = 1'b0;
      expReq = (c >= 2) && (c % 2 == 0) && (c <= 2 + 2 * expK);
      if (expReq) lastAddr = expAddr[(c - 2) / 2];
      if (c == doneCyc) lastRes = expRes;
      checkOutput($sformatf("job%0d c%0d occ_req", jobNum, c), 32'(occ_req), 32'(expReq));
      checkOutput($sformatf("job%0d c%0d occ_addr", jobNum, c), 32'({occ_ix, occ_iy, occ_iz}), 32'(lastAddr));
      checkOutput($sformatf("job%0d c%0d job_done", jobNum, c), 32'(job_done), 32'(c == doneCyc));
      checkOutput($sformatf("job%0d c%0d res", jobNum, c), 32'(resObs), 32'(lastRes));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " occ_req"}, 32'(occ_req), 32'd0);
    checkOutput({tag, " occ_addr"}, 32'({occ_ix, occ_iy, occ_iz}), 32'd0);
    checkOutput({tag, " job_done"}, 32'(job_done), 32'd0);
    checkOutput({tag, " res"}, 32'(resObs), 32'd0);
  endtask

  task automatic setJob(input int x, input int y, input int z, input bit dx, input bit dy, input bit dz,
                        input logic [W-1:0] nx, input logic [W-1:0] ny, input logic [W-1:0] nz,
                        input logic [W-1:0] ix, input logic [W-1:0] iy, input logic [W-1:0] iz,
                        input int budget);
    ix0 = 5'(x); iy0 = 5'(y); iz0 = 5'(z);
    sx = dx; sy = dy; sz = dz;
    nextX = nx; nextY = ny; nextZ = nz;
    incX = ix; incY = iy; incZ = iz;
    maxSteps = 10'(budget);
  endtask

  initial begin
    $display("[TB] dda_stepper bench start");
    fillMap(0);
    repeat (3) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b0;

    // Start-voxel hit
    occMap[3 * 1024 + 4 * 32 + 5] = 1'b1;
    setJob(3, 4, 5, 1, 1, 1, 24'h10, 24'h20, 24'h30, 24'h1, 24'h1, 24'h1, 10);
    applyStimulus();

    // +x walk to (6,4,5)
    fillMap(0);
    occMap[6 * 1024 + 4 * 32 + 5] = 1'b1;
    setJob(3, 4, 5, 1, 1, 1, 24'h000100, 24'hFFFFFF, 24'hFFFFFF, 24'h000200, 24'h1, 24'h1, 10);
    applyStimulus();

    // Tie-break x over y, budget stop
    fillMap(0);
    setJob(10, 10, 10, 1, 1, 1, 24'h10, 24'h10, 24'hFFFFF0, 24'h20, 24'h20, 24'h100, 4);
    applyStimulus();

    // Saturated z timer ties with x/y and loses the tie
    setJob(10, 10, 10, 1, 1, 1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h10, 24'h10, 24'hFFFF00, 4);
    applyStimulus();

    // Exit on -x from index 0
    setJob(0, 9, 9, 0, 1, 1, 24'h1, 24'hFFFFFF, 24'hFFFFFF, 24'h1, 24'h1, 24'h1, 10);
    applyStimulus();

    // Exit on +z after one step from 30
    setJob(5, 5, 30, 1, 1, 1, 24'hFFFFFF, 24'hFFFFFF, 24'h1, 24'h1, 24'h1, 24'h1, 10);
    applyStimulus();

    // Zero budget with an empty start voxel
    setJob(7, 8, 9, 1, 0, 1, 24'h5, 24'h6, 24'h7, 24'h1, 24'h1, 24'h1, 0);
    applyStimulus();

    // Reset during cycle 5 of a 3-step job aborts it silently
    occMap[6 * 1024 + 4 * 32 + 5] = 1'b1;
    setJob(3, 4, 5, 1, 1, 1, 24'h000100, 24'hFFFFFF, 24'hFFFFFF, 24'h000200, 24'h1, 24'h1, 10);
    @(negedge clock);
    @(negedge clock);
    jobLoaded = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      jobLoaded = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    checkAllZero("midreset");
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      checkAllZero($sformatf("postreset c%0d", c));
    end
    lastAddr = '0;
    lastRes = '0;
    applyStimulus();

    // Randomized jobs
    for (int j = 0; j < 40; j++) begin
      case ($urandom_range(0, 2))
        0: fillMap(0);
        1: fillMap(8);
        default: fillMap(64);
      endcase
      ix0 = 5'($urandom); iy0 = 5'($urandom); iz0 = 5'($urandom);
      sx = 1'($urandom); sy = 1'($urandom); sz = 1'($urandom);
      nextX = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom_range(0, 4095));
      nextY = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom_range(0, 4095));
      nextZ = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom_range(0, 4095));
      incX = ($urandom_range(0, 3) == 0) ? (24'hF00000 | 24'($urandom)) : 24'($urandom_range(0, 1023));
      incY = ($urandom_range(0, 3) == 0) ? (24'hF00000 | 24'($urandom)) : 24'($urandom_range(0, 1023));
      incZ = ($urandom_range(0, 3) == 0) ? (24'hF00000 | 24'($urandom)) : 24'($urandom_range(0, 1023));
      maxSteps = 10'($urandom_range(0, 60));
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
